// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter between VGA scanout and the drawing engine.
// One RAM access per clock: scanout normally wins, and a starvation counter
// forces a draw grant after STARVE_MAX consecutive denied draw cycles.
// Read data is steered back to its requester by a two-stage owner tag pipe
// that tracks the one-cycle RAM read latency plus the registered address stage.
module vga_fb_arbiter #(
   parameter int ADDR_W     = 17,
   parameter int DATA_W     = 8,
   parameter int STARVE_MAX = 8
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              scan_req,
   input  logic [ADDR_W-1:0] scan_addr,
   output logic              scan_ack,
   output logic              scan_rvalid,
   output logic [DATA_W-1:0] scan_rdata,
   input  logic              draw_valid,
   input  logic              draw_we,
   input  logic [ADDR_W-1:0] draw_addr,
   input  logic [DATA_W-1:0] draw_wdata,
   output logic              draw_ready,
   output logic              draw_rvalid,
   output logic [DATA_W-1:0] draw_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [15:0]       draw_stall_cnt
);

   typedef enum logic {
      PRI_SCAN   = 1'b0,
      FORCE_DRAW = 1'b1
   } arbState_t;

   typedef enum logic {
      OWNER_SCAN = 1'b0,
      OWNER_DRAW = 1'b1
   } owner_t;

   localparam logic [7:0] STARVE_LIMIT = 8'(STARVE_MAX);

   arbState_t  state;
   arbState_t  stateNext;
   logic [7:0] starveCnt;
   logic [7:0] starveCntNext;
   logic       scanGrant;
   logic       drawGrant;
   logic       tag0Valid;
   owner_t     tag0Owner;
   logic       tag1Valid;
   owner_t     tag1Owner;

   // Arbiter state and starvation counter registers.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state     <= PRI_SCAN;
         starveCnt <= 8'd0;
      end else begin
         state     <= stateNext;
         starveCnt <= starveCntNext;
      end
   end

   // Grant decision, starvation counting and next-state logic; no grants while reset is high.
   always_comb begin
      scanGrant     = 1'b0;
      drawGrant     = 1'b0;
      stateNext     = state;
      starveCntNext = 8'd0;
      if (!reset) begin
         if (state == FORCE_DRAW && draw_valid) begin
            drawGrant = 1'b1;
         end else if (scan_req) begin
            scanGrant = 1'b1;
         end else if (draw_valid) begin
            drawGrant = 1'b1;
         end
      end
      if (draw_valid && !drawGrant) begin
         starveCntNext = (starveCnt == 8'hFF) ? starveCnt : starveCnt + 8'd1;
      end
      // The forced grant lands on the cycle right after the limit is reached,
      // so a continuously blocked drawer gets one slot every STARVE_MAX+1 cycles.
      case (state)
         PRI_SCAN: begin
            if (starveCntNext == STARVE_LIMIT) begin
               stateNext = FORCE_DRAW;
            end
         end
         FORCE_DRAW: begin
            if (drawGrant || !draw_valid) begin
               stateNext = PRI_SCAN;
            end
         end
         default: stateNext = PRI_SCAN;
      endcase
   end

   assign scan_ack   = scanGrant;
   assign draw_ready = drawGrant;

   // Register the granted access onto the RAM port; idle cycles hold the address.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         mem_addr  <= '0;
         mem_we    <= 1'b0;
         mem_wdata <= '0;
      end else if (scanGrant) begin
         mem_addr <= scan_addr;
         mem_we   <= 1'b0;
      end else if (drawGrant) begin
         mem_addr  <= draw_addr;
         mem_we    <= draw_we;
         mem_wdata <= draw_wdata;
      end else begin
         mem_we <= 1'b0;
      end
   end

   // Owner tag pipeline: stage 0 aligns with mem_addr, stage 1 with mem_rdata.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         tag0Valid <= 1'b0;
         tag0Owner <= OWNER_SCAN;
         tag1Valid <= 1'b0;
         tag1Owner <= OWNER_SCAN;
      end else begin
         tag0Valid <= scanGrant || (drawGrant && !draw_we);
         tag0Owner <= scanGrant ? OWNER_SCAN : OWNER_DRAW;
         tag1Valid <= tag0Valid;
         tag1Owner <= tag0Owner;
      end
   end

   assign scan_rvalid = tag1Valid && (tag1Owner == OWNER_SCAN);
   assign draw_rvalid = tag1Valid && (tag1Owner == OWNER_DRAW);
   assign scan_rdata  = mem_rdata;
   assign draw_rdata  = mem_rdata;

   // Saturating count of cycles the drawing engine spent waiting.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         draw_stall_cnt <= 16'd0;
      end else if (draw_valid && !drawGrant && draw_stall_cnt != 16'hFFFF) begin
         draw_stall_cnt <= draw_stall_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: directed stimulus pushes expected read returns
// into a scoreboard queue; a negedge monitor pops and checks each return.
// A second instance with STARVE_MAX=255 is used for stall counter saturation.
module tb_vga_fb_arbiter;

   localparam int ADDR_W = 17;
   localparam int DATA_W = 8;

   typedef struct {
      bit                isDraw;
      logic [DATA_W-1:0] data;
      int                due;
   } expEntry_t;

   logic              CLOCK_50;
   logic              reset;
   logic              scanReq;
   logic [ADDR_W-1:0] scanAddr;
   logic              drawValid;
   logic              drawWe;
   logic [ADDR_W-1:0] drawAddr;
   logic [DATA_W-1:0] drawWdata;
   logic [DATA_W-1:0] memRdata;

   logic              scanAck, scanRvalid, drawReady, drawRvalid, memWe;
   logic [DATA_W-1:0] scanRdata, drawRdata, memWdata;
   logic [ADDR_W-1:0] memAddr;
   logic [15:0]       stallCnt;

   logic              scanAck2, scanRvalid2, drawReady2, drawRvalid2, memWe2;
   logic [DATA_W-1:0] scanRdata2, drawRdata2, memWdata2;
   logic [ADDR_W-1:0] memAddr2;
   logic [15:0]       stallCnt2;

   logic [DATA_W-1:0] fbMem [0:(1<<ADDR_W)-1];
   expEntry_t         sbQ[$];
   int                cyc;
   int                total;
   int                bad;

   vga_fb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(8)) dut (
      .CLOCK_50(CLOCK_50), .reset(reset),
      .scan_req(scanReq), .scan_addr(scanAddr), .scan_ack(scanAck),
      .scan_rvalid(scanRvalid), .scan_rdata(scanRdata),
      .draw_valid(drawValid), .draw_we(drawWe), .draw_addr(drawAddr),
      .draw_wdata(drawWdata), .draw_ready(drawReady),
      .draw_rvalid(drawRvalid), .draw_rdata(drawRdata),
      .mem_addr(memAddr), .mem_we(memWe), .mem_wdata(memWdata),
      .mem_rdata(memRdata), .draw_stall_cnt(stallCnt)
   );

   vga_fb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(255)) dutSat (
      .CLOCK_50(CLOCK_50), .reset(reset),
      .scan_req(scanReq), .scan_addr(scanAddr), .scan_ack(scanAck2),
      .scan_rvalid(scanRvalid2), .scan_rdata(scanRdata2),
      .draw_valid(drawValid), .draw_we(drawWe), .draw_addr(drawAddr),
      .draw_wdata(drawWdata), .draw_ready(drawReady2),
      .draw_rvalid(drawRvalid2), .draw_rdata(drawRdata2),
      .mem_addr(memAddr2), .mem_we(memWe2), .mem_wdata(memWdata2),
      .mem_rdata(8'h00), .draw_stall_cnt(stallCnt2)
   );

   // Free-running 100 MHz-style clock.
   initial begin
      CLOCK_50 = 1'b0;
      forever #5 CLOCK_50 = ~CLOCK_50;
   end

   // Cycle counter used to time expected read returns.
   always @(posedge CLOCK_50) cyc <= cyc + 1;

   // Synchronous single-port framebuffer model, read-first.
   always @(posedge CLOCK_50) begin
      if (memWe) fbMem[memAddr] <= memWdata;
      memRdata <= fbMem[memAddr];
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic applyStimulus(input logic sReq, input logic [ADDR_W-1:0] sAddr,
                                input logic dValid, input logic dWe,
                                input logic [ADDR_W-1:0] dAddr, input logic [DATA_W-1:0] dData);
      @(posedge CLOCK_50);
      #1;
      scanReq   = sReq;
      scanAddr  = sAddr;
      drawValid = dValid;
      drawWe    = dWe;
      drawAddr  = dAddr;
      drawWdata = dData;
   endtask

   task automatic expectRead(input bit isDraw, input logic [DATA_W-1:0] data);
      expEntry_t e;
      e.isDraw = isDraw;
      e.data   = data;
      e.due    = cyc + 2;
      sbQ.push_back(e);
   endtask

   task automatic doReset();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
      repeat (3) @(posedge CLOCK_50);
      #1 reset = 1'b1;
      @(posedge CLOCK_50);
      #1 reset = 1'b0;
   endtask

   // Scoreboard monitor: every cycle either the due read returns or no rvalid at all.
   always @(negedge CLOCK_50) begin
      expEntry_t e;
      if (sbQ.size() > 0 && sbQ[0].due == cyc) begin
         e = sbQ.pop_front();
         checkOutput(e.isDraw ? "draw return" : "scan return",
                     {22'd0, scanRvalid, drawRvalid, (e.isDraw ? drawRdata : scanRdata)},
                     {22'd0, ~e.isDraw, e.isDraw, e.data});
      end else begin
         checkOutput("no stray rvalid", {30'd0, scanRvalid, drawRvalid}, 32'd0);
      end
   end

   initial begin
      cyc   = 0;
      total = 0;
      bad   = 0;
      for (int a = 0; a < (1 << ADDR_W); a++) fbMem[a] = '0;
      fbMem[0] = 8'h11;
      fbMem[1] = 8'h22;
      fbMem[2] = 8'h33;
      fbMem[4] = 8'h44;

      // Reset values, with every request asserted to prove grants are gated.
      reset     = 1'b1;
      scanReq   = 1'b1;
      scanAddr  = 17'h00007;
      drawValid = 1'b1;
      drawWe    = 1'b1;
      drawAddr  = 17'h00009;
      drawWdata = 8'hFF;
      @(negedge CLOCK_50);
      checkOutput("reset mem_addr", 32'(memAddr), 32'd0);
      checkOutput("reset mem_we", 32'(memWe), 32'd0);
      checkOutput("reset mem_wdata", 32'(memWdata), 32'd0);
      checkOutput("reset stall_cnt", 32'(stallCnt), 32'd0);
      checkOutput("reset scan_ack", 32'(scanAck), 32'd0);
      checkOutput("reset draw_ready", 32'(drawReady), 32'd0);
      @(posedge CLOCK_50);
      #1 reset = 1'b0;
      scanReq   = 1'b0;
      drawValid = 1'b0;

      // Simultaneous requests with idle starvation counter.
      doReset();
      applyStimulus(1'b1, 17'h00002, 1'b1, 1'b0, 17'h00003, 8'h00);
      expectRead(1'b0, 8'h33);
      @(negedge CLOCK_50);
      checkOutput("simul scan_ack", 32'(scanAck), 32'd1);
      checkOutput("simul draw_ready", 32'(drawReady), 32'd0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
      @(negedge CLOCK_50);
      checkOutput("simul stall_cnt", 32'(stallCnt), 32'd1);
      checkOutput("simul mem_addr", 32'(memAddr), 32'h00002);

      // Reset arriving one cycle after a scan read grant.
      doReset();
      applyStimulus(1'b1, 17'h00010, 1'b0, 1'b0, '0, '0);
      @(negedge CLOCK_50);
      checkOutput("midrst scan_ack", 32'(scanAck), 32'd1);
      @(posedge CLOCK_50);
      #1 reset = 1'b1;
      @(negedge CLOCK_50);
      checkOutput("midrst mem_addr", 32'(memAddr), 32'd0);
      checkOutput("midrst mem_we", 32'(memWe), 32'd0);
      checkOutput("midrst scan_ack gated", 32'(scanAck), 32'd0);
      @(negedge CLOCK_50);
      checkOutput("midrst scan_rvalid", 32'(scanRvalid), 32'd0);
      @(posedge CLOCK_50);
      #1 reset = 1'b0;
      scanReq = 1'b0;

      // Starvation forcing: draw wins on cycles 9 and 18 only.
      doReset();
      for (int i = 1; i <= 20; i++) begin
         applyStimulus(1'b1, 17'h00004, 1'b1, 1'b1, 17'h12C00, 8'hA5);
         if (!(i == 9 || i == 18)) expectRead(1'b0, 8'h44);
         @(negedge CLOCK_50);
         checkOutput($sformatf("starve draw_ready c%0d", i), 32'(drawReady), 32'((i == 9) || (i == 18)));
         checkOutput($sformatf("starve scan_ack c%0d", i), 32'(scanAck), 32'(!((i == 9) || (i == 18))));
      end
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 17'h12C00, 8'h00);
      expectRead(1'b1, 8'hA5);
      @(negedge CLOCK_50);
      checkOutput("starve readback ready", 32'(drawReady), 32'd1);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
      @(negedge CLOCK_50);
      checkOutput("starve mem 0x12C00", 32'(fbMem[17'h12C00]), 32'hA5);

      // Write followed immediately by a read of the same address.
      doReset();
      applyStimulus(1'b0, '0, 1'b1, 1'b1, 17'h00005, 8'h3C);
      @(negedge CLOCK_50);
      checkOutput("raw write ready", 32'(drawReady), 32'd1);
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 17'h00005, 8'h00);
      expectRead(1'b1, 8'h3C);
      @(negedge CLOCK_50);
      checkOutput("raw read ready", 32'(drawReady), 32'd1);
      checkOutput("raw mem_we", 32'(memWe), 32'd1);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);

      // Interleaved scan and draw reads, back to back.
      doReset();
      applyStimulus(1'b1, 17'h00000, 1'b0, 1'b0, '0, '0);
      expectRead(1'b0, 8'h11);
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 17'h00001, 8'h00);
      expectRead(1'b1, 8'h22);
      applyStimulus(1'b1, 17'h00001, 1'b0, 1'b0, '0, '0);
      expectRead(1'b0, 8'h22);
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 17'h00000, 8'h00);
      expectRead(1'b1, 8'h11);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);

      // Long contention: 70000 cycles, draw forced every 9th cycle on the main instance.
      doReset();
      for (int i = 1; i <= 70000; i++) begin
         applyStimulus(1'b1, 17'h00004, 1'b1, 1'b1, 17'h12C00, 8'hA5);
         if (i % 9 != 0) expectRead(1'b0, 8'h44);
      end
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
      @(negedge CLOCK_50);
      checkOutput("sat stall_cnt K=255", 32'(stallCnt2), 32'h0000FFFF);
      checkOutput("long stall_cnt K=8", 32'(stallCnt), 32'd62223);
      applyStimulus(1'b1, 17'h00004, 1'b1, 1'b1, 17'h12C00, 8'hA5);
      expectRead(1'b0, 8'h44);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
      @(negedge CLOCK_50);
      checkOutput("sat stall_cnt no wrap", 32'(stallCnt2), 32'h0000FFFF);

      repeat (4) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      checkOutput("scoreboard drained", 32'(sbQ.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
